video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator. It produces pixel coordinates, sync pulses, a visible-area flag and line/frame strobes for any progressive video mode. A pixel-clock enable lets it run from the system clock. A configurable delay line aligns sync and visible flags with a downstream pixel-fetch pipeline. It sits at the head of the video path and feeds the framebuffer reader and the DAC/sync output stage.

## Interface
Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels); must be ≥1
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); must be ≥1
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync
- COORD_W, 16, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1
- DELAY, 0, number of pix_en ticks by which hsync/vsync/visible/strobes lag x/y (0..15)

Derived values: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL is defined the same way.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; state advances only on edges where pix_en=1
- x  out  COORD_W  current horizontal count, 0..H_TOTAL-1
- y  out  COORD_W  current vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at HSYNC_POL level when asserted
- vsync  out  1  vertical sync at VSYNC_POL level when asserted
- visible  out  1  high when in the active area
- line_start  out  1  high for the tick where x=0
- frame_start  out  1  high for the tick where x=0 and y=0

## Operation
- Counter order along each axis is visible, then front porch, then sync, then back porch.
- x increments on each tick. At x=H_TOTAL-1 it wraps to 0 and y increments. At x=H_TOTAL-1 and y=V_TOTAL-1, both wrap to 0.
- Undelayed flags for coordinate (x,y):
  - vis = x<H_VISIBLE && y<V_VISIBLE.
  - hs = H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC.
  - vs = V_VISIBLE+V_FRONT ≤ y < V_VISIBLE+V_FRONT+V_SYNC. vs holds for whole lines, so it changes only at x=0.
  - ls = (x==0); fs = (x==0 && y==0).
- Output flags are the undelayed flags passed through a DELAY-stage shift register. The register advances only on pix_en ticks. With DELAY=0 there is no shift register, but the flags are still registered.
- Polarity is applied at the output: hsync = hs ? HSYNC_POL : !HSYNC_POL. vsync is formed the same way with VSYNC_POL.
- Comparisons are unsigned at COORD_W width. No arithmetic overflow is possible when the parameters are legal.

## Timing
- Reset applies on any edge with reset=1, overriding pix_en.
  - x=H_TOTAL-1, y=V_TOTAL-1.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL.
  - visible=0, line_start=0, frame_start=0.
  - All delay stages are cleared to inactive.
  - The reset state is the last back-porch pixel, so these flag values are self-consistent.
- First pix_en tick after reset: x=0, y=0.
  - With DELAY=0, visible=1, line_start=1 and frame_start=1 on that same cycle.
  - With DELAY=N, the flags for (0,0) appear N ticks later, and they are inactive until then.
- All outputs are registered and change only on pix_en ticks. They hold their value while pix_en=0, so strobes last exactly one tick period, not one clk cycle.
- Reset asserted mid-frame returns the block to the reset state on that edge. Timing then restarts at (0,0) on the next tick; no partial frame is resumed.
- pix_en=1 on every clock gives one pixel per clk.

## Test plan
- Defaults, DELAY=0, pix_en=1: release reset, then check the first cycle is x=0, y=0, visible=1, frame_start=1.
  - hsync goes low at x=656 and returns high at x=752.
  - x wraps 799→0 with y incrementing.
  - vsync is low exactly for y=490..491.
  - The next frame_start occurs 420000 clocks after the first.
- Small mode (H 8/2/2/2, V 4/1/1/1, pol=1), pix_en=1:
  - visible=1 for x 0..7 on y 0..3 and never otherwise.
  - hsync=1 at x=10..11.
  - vsync=1 on all of y=5.
  - Frame period is 98 clocks.
- Small mode with pix_en=1 every third clk:
  - Outputs change only on enabled edges.
  - line_start stays high for 3 clks.
  - Frame period is 294 clocks.
- Small mode, DELAY=3:
  - frame_start, visible and hsync edges occur exactly 3 ticks after the matching x/y values.
  - Flags are inactive for the first 3 ticks after reset.
- Reset asserted at x=5, y=2 with pix_en=0:
  - On that edge the outputs take reset values (x=13, y=6).
  - After release, the next tick gives x=0, y=0, frame_start=1.
- Reset held high with pix_en toggling: x and y stay at their reset values and no strobes fire.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel coordinates, sync pulses, visible flag and
// line/frame strobes for a progressive mode, with an optional flag delay line.
module video_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COORD_W   = 16,
    parameter int unsigned DELAY     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               visible,
    output logic               line_start,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_BEG = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    // Flag vector layout; all bits are active-high inside the pipeline.
    localparam int unsigned F_HS   = 0;
    localparam int unsigned F_VS   = 1;
    localparam int unsigned F_VIS  = 2;
    localparam int unsigned F_LS   = 3;
    localparam int unsigned F_FS   = 4;
    localparam int unsigned FLAG_W = 5;

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] w_x_nxt;
    logic [COORD_W-1:0] w_y_nxt;
    logic [FLAG_W-1:0]  w_flags_nxt;
    // Stage 0 holds flags of the current x/y; stage DELAY drives the outputs.
    logic [FLAG_W-1:0]  r_pipe [0:DELAY];

    // Next raster position: x wraps at end of line, y wraps at end of frame.
    always_comb begin
        w_x_nxt = r_x + COORD_W'(1);
        w_y_nxt = r_y;
        if (r_x == H_LAST) begin
            w_x_nxt = '0;
            w_y_nxt = (r_y == V_LAST) ? '0 : r_y + COORD_W'(1);
        end
    end

    // Undelayed flags for the position being entered on this tick.
    always_comb begin
        w_flags_nxt        = '0;
        w_flags_nxt[F_VIS] = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
        w_flags_nxt[F_HS]  = (w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END);
        w_flags_nxt[F_VS]  = (w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END);
        w_flags_nxt[F_LS]  = (w_x_nxt == '0);
        w_flags_nxt[F_FS]  = (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    // Counters and flag delay line; both advance only on pixel ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x <= H_LAST;
            r_y <= V_LAST;
            for (int i = 0; i <= int'(DELAY); i++) begin
                r_pipe[i] <= '0;
            end
        end else if (pix_en) begin
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
            r_pipe[0] <= w_flags_nxt;
            for (int i = 1; i <= int'(DELAY); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    // Polarity is a constant inversion of a registered bit, so outputs stay glitch-free.
    assign hsync       = r_pipe[DELAY][F_HS] ? HSYNC_POL : ~HSYNC_POL;
    assign vsync       = r_pipe[DELAY][F_VS] ? VSYNC_POL : ~VSYNC_POL;
    assign visible     = r_pipe[DELAY][F_VIS];
    assign line_start  = r_pipe[DELAY][F_LS];
    assign frame_start = r_pipe[DELAY][F_FS];

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: three instances (small mode undelayed,
// small mode with DELAY=3, default VGA mode) share clk/reset/pix_en; expected
// outputs come from a tick-count model of the raster.
module tb_video_timing_gen;

    logic clk;
    logic reset;
    logic pix_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        hs;
        logic        vs;
        logic        vis;
        logic        ls;
        logic        fs;
    } exp_t;

    typedef struct packed {
        exp_t s0;
        exp_t s3;
        exp_t df;
    } entry_t;

    entry_t sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     t     = -1;   // ticks since last reset; -1 before the first reset

    logic [15:0] s0_x, s0_y, s3_x, s3_y, df_x, df_y;
    logic s0_hs, s0_vs, s0_vis, s0_ls, s0_fs;
    logic s3_hs, s3_vs, s3_vis, s3_ls, s3_fs;
    logic df_hs, df_vs, df_vis, df_ls, df_fs;

    video_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(16), .DELAY(0)
    ) u_s0 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(s0_x), .y(s0_y), .hsync(s0_hs), .vsync(s0_vs),
        .visible(s0_vis), .line_start(s0_ls), .frame_start(s0_fs)
    );

    video_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(16), .DELAY(3)
    ) u_s3 (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(s3_x), .y(s3_y), .hsync(s3_hs), .vsync(s3_vs),
        .visible(s3_vis), .line_start(s3_ls), .frame_start(s3_fs)
    );

    video_timing_gen u_df (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .x(df_x), .y(df_y), .hsync(df_hs), .vsync(df_vs),
        .visible(df_vis), .line_start(df_ls), .frame_start(df_fs)
    );

    // Reference: position is simply the tick count modulo the frame size.
    function automatic exp_t model(input int tk, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input bit hp, input bit vp, input int dly);
        exp_t e;
        int ht, vt, total, p, fx, fy;
        bit a_hs, a_vs;
        ht    = hv + hf + hsw + hb;
        vt    = vv + vf + vsw + vb;
        total = ht * vt;
        if (tk == 0) begin
            e.x = 16'(ht - 1);
            e.y = 16'(vt - 1);
        end else begin
            p   = (tk - 1) % total;
            e.x = 16'(p % ht);
            e.y = 16'(p / ht);
        end
        a_hs = 1'b0; a_vs = 1'b0;
        e.vis = 1'b0; e.ls = 1'b0; e.fs = 1'b0;
        if (tk > dly) begin
            p     = (tk - 1 - dly) % total;
            fx    = p % ht;
            fy    = p / ht;
            e.vis = (fx < hv) && (fy < vv);
            a_hs  = (fx >= hv + hf) && (fx < hv + hf + hsw);
            a_vs  = (fy >= vv + vf) && (fy < vv + vf + vsw);
            e.ls  = (fx == 0);
            e.fs  = (fx == 0) && (fy == 0);
        end
        e.hs = a_hs ? hp : ~hp;
        e.vs = a_vs ? vp : ~vp;
        return e;
    endfunction

    // One clock with the given inputs; the model advances and pushes its expectation.
    task automatic step(input logic rst, input logic en);
        entry_t ent;
        reset  = rst;
        pix_en = en;
        @(posedge clk);
        if (rst)            t = 0;
        else if (en && t >= 0) t = t + 1;
        if (t >= 0) begin
            ent.s0 = model(t, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 0);
            ent.s3 = model(t, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 3);
            ent.df = model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 0);
            sb_q.push_back(ent);
        end
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s t=%0d got=%0d expected=%0d", nm, t, act, req);
        end
    endtask

    task automatic chk_inst(input string nm, input exp_t e, input logic [15:0] ax,
                            input logic [15:0] ay, input logic ahs, input logic avs,
                            input logic avis, input logic als, input logic afs);
        chk({nm, ".x"},           int'(ax),   int'(e.x));
        chk({nm, ".y"},           int'(ay),   int'(e.y));
        chk({nm, ".hsync"},       int'(ahs),  int'(e.hs));
        chk({nm, ".vsync"},       int'(avs),  int'(e.vs));
        chk({nm, ".visible"},     int'(avis), int'(e.vis));
        chk({nm, ".line_start"},  int'(als),  int'(e.ls));
        chk({nm, ".frame_start"}, int'(afs),  int'(e.fs));
    endtask

    // Monitor: outputs are presented every clock; pop and compare away from the edge.
    always @(negedge clk) begin
        entry_t ent;
        if (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            chk_inst("s0", ent.s0, s0_x, s0_y, s0_hs, s0_vs, s0_vis, s0_ls, s0_fs);
            chk_inst("s3", ent.s3, s3_x, s3_y, s3_hs, s3_vs, s3_vis, s3_ls, s3_fs);
            chk_inst("df", ent.df, df_x, df_y, df_hs, df_vs, df_vis, df_ls, df_fs);
        end
    end

    initial begin
        int guard;
        reset  = 1'b1;
        pix_en = 1'b0;

        // Reset held while pix_en toggles: counters stay put, no strobes.
        for (int i = 0; i < 8; i++) step(1'b1, 1'(i % 2));

        // Continuous ticks: several small frames and a few default lines.
        repeat (2000) step(1'b0, 1'b1);

        // One tick every third clock.
        step(1'b1, 1'b0);
        for (int i = 0; i < 900; i++) step(1'b0, 1'((i % 3) == 2));

        // Reset at small-mode x=5,y=2 (33 pixels into the frame) with pix_en low.
        step(1'b1, 1'b0);
        repeat (34) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b1);

        // Random ticks with occasional mid-frame resets.
        for (int i = 0; i < 5000; i++) begin
            step(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (sb_q.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain remaining=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
